// File: rtl/preg_ready_table_pkg.sv
// rtl/preg_ready_table_pkg.sv - shared widths and types for the physical-register ready scoreboard
package preg_ready_table_pkg;

  localparam int PREG_W   = 7;
  localparam int NUM_PREG = 128;
  localparam int NUM_WB   = 3;
  localparam int NUM_Q    = 2;

  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    preg_t tag;
    logic  valid;
  } wb_bcast_t;

endpackage

// File: rtl/preg_onehot_dec.sv
// rtl/preg_onehot_dec.sv - physical-register tag to one-hot decoder with enable
module preg_onehot_dec
  import preg_ready_table_pkg::*;
(
  input  logic                en_i,
  input  preg_t               tag_i,
  output logic [NUM_PREG-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[tag_i] = 1'b1;
  end

endmodule

// File: rtl/preg_ready_table.sv
// rtl/preg_ready_table.sv - preg ready bits, writeback rebroadcast, rename queries and one branch checkpoint
module preg_ready_table
  import preg_ready_table_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           nr_valid,
  input  preg_t                          nr_reg,
  input  logic [NUM_WB-1:0]              wb_valid,
  input  logic [NUM_WB-1:0][PREG_W-1:0]  wb_preg,
  input  logic [NUM_Q-1:0][PREG_W-1:0]   q_preg,
  output logic [NUM_Q-1:0]               q_ready,
  output preg_t                          preg1_rdy,
  output preg_t                          preg2_rdy,
  output preg_t                          preg3_rdy,
  output logic                           preg1_valid,
  output logic                           preg2_valid,
  output logic                           preg3_valid,
  input  logic                           ckpt_take,
  input  logic                           mispredict,
  output logic                           ckpt_valid
);

  logic [NUM_PREG-1:0] ready_q, ready_d;
  logic [NUM_PREG-1:0] snap_q, snap_d;
  logic                snap_v_q, snap_v_d;
  wb_bcast_t [NUM_WB-1:0] bcast_q, bcast_d;

  logic [NUM_WB-1:0][NUM_PREG-1:0] wb_dec;
  logic [NUM_PREG-1:0] set_vec, clr_vec, ready_nxt;

  // Tag 0 is the hardwired-ready register, so it never reaches the decoders.
  for (genvar g = 0; g < NUM_WB; g++) begin : g_wb_dec
    preg_onehot_dec u_wb_dec (
      .en_i     (wb_valid[g] && (wb_preg[g] != '0)),
      .tag_i    (wb_preg[g]),
      .onehot_o (wb_dec[g])
    );
  end

  preg_onehot_dec u_nr_dec (
    .en_i     (nr_valid && (nr_reg != '0)),
    .tag_i    (nr_reg),
    .onehot_o (clr_vec)
  );

  always_comb begin
    set_vec = '0;
    for (int p = 0; p < NUM_WB; p++) set_vec = set_vec | wb_dec[p];
  end

  // A writeback to a tag being reallocated this cycle is stale; the clear wins.
  assign ready_nxt = (ready_q | set_vec) & ~clr_vec;

  always_comb begin
    ready_d  = ready_nxt;
    snap_d   = snap_q;
    snap_v_d = snap_v_q;
    if (mispredict) begin
      ready_d  = (snap_v_q ? snap_q : ready_q) | set_vec;
      snap_v_d = 1'b0;
    end else if (ckpt_take) begin
      snap_d   = ready_nxt;
      snap_v_d = 1'b1;
    end else if (snap_v_q) begin
      snap_d   = snap_q | set_vec;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_WB; p++) begin
      bcast_d[p].tag   = wb_preg[p];
      bcast_d[p].valid = wb_valid[p];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ready_q  <= '1;
      snap_q   <= '1;
      snap_v_q <= 1'b0;
      bcast_q  <= '0;
    end else begin
      ready_q  <= ready_d;
      snap_q   <= snap_d;
      snap_v_q <= snap_v_d;
      bcast_q  <= bcast_d;
    end
  end

  // Same-cycle writebacks are bypassed to rename; same-cycle allocation is not.
  always_comb begin
    q_ready = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      q_ready[i] = ready_q[q_preg[i]] || (q_preg[i] == '0);
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_valid[p] && (wb_preg[p] == q_preg[i])) q_ready[i] = 1'b1;
      end
    end
  end

  assign preg1_rdy   = bcast_q[0].tag;
  assign preg2_rdy   = bcast_q[1].tag;
  assign preg3_rdy   = bcast_q[2].tag;
  assign preg1_valid = bcast_q[0].valid;
  assign preg2_valid = bcast_q[1].valid;
  assign preg3_valid = bcast_q[2].valid;
  assign ckpt_valid  = snap_v_q;

  // A writeback should only ever land on a busy register.
  always @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_WB; p++) begin
        assert (!(wb_valid[p] && (wb_preg[p] != '0) && ready_q[wb_preg[p]]));
      end
    end
  end

endmodule

// File: tb/tb_preg_ready_table.sv
// tb/tb_preg_ready_table.sv - randomized and directed checks of preg_ready_table against a tag-level model
module tb_preg_ready_table;
  import preg_ready_table_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic nr_valid = 1'b0;
  preg_t nr_reg = '0;
  logic [NUM_WB-1:0] wb_valid = '0;
  logic [NUM_WB-1:0][PREG_W-1:0] wb_preg = '0;
  logic [NUM_Q-1:0][PREG_W-1:0] q_preg = '0;
  logic [NUM_Q-1:0] q_ready;
  preg_t preg1_rdy, preg2_rdy, preg3_rdy;
  logic preg1_valid, preg2_valid, preg3_valid;
  logic ckpt_take = 1'b0;
  logic mispredict = 1'b0;
  logic ckpt_valid;

  preg_ready_table dut (
    .clk(clk), .reset(reset), .nr_valid(nr_valid), .nr_reg(nr_reg),
    .wb_valid(wb_valid), .wb_preg(wb_preg), .q_preg(q_preg), .q_ready(q_ready),
    .preg1_rdy(preg1_rdy), .preg2_rdy(preg2_rdy), .preg3_rdy(preg3_rdy),
    .preg1_valid(preg1_valid), .preg2_valid(preg2_valid), .preg3_valid(preg3_valid),
    .ckpt_take(ckpt_take), .mispredict(mispredict), .ckpt_valid(ckpt_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic ready_m [NUM_PREG];
  logic snap_m  [NUM_PREG];
  logic snapv_m;

  logic [1:0] s_q;
  logic [2:0] s_bv;
  preg_t      s_b1, s_b2, s_b3;
  logic       s_ck;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < NUM_PREG; t++) begin
      ready_m[t] = 1'b1;
      snap_m[t]  = 1'b1;
    end
    snapv_m = 1'b0;
  endtask

  function automatic logic q_exp(input preg_t t, input logic [2:0] wv,
                                 input preg_t w0, input preg_t w1, input preg_t w2);
    return (t == 0) || ready_m[t] || (wv[0] && w0 == t) || (wv[1] && w1 == t) || (wv[2] && w2 == t);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    nr_valid = 1'b0; wb_valid = '0; ckpt_take = 1'b0; mispredict = 1'b0;
    @(posedge clk);
    #1;
    check("rst_b_valid", {preg1_valid, preg2_valid, preg3_valid}, 3'b000);
    check("rst_b_tags", {preg1_rdy, preg2_rdy, preg3_rdy}, 21'd0);
    check("rst_ckpt", ckpt_valid, 1'b0);
    model_reset();
    reset = 1'b1;
  endtask

  task automatic cyc(input logic nv, input preg_t nr, input logic [2:0] wv,
                     input preg_t w0, input preg_t w1, input preg_t w2,
                     input preg_t q0, input preg_t q1, input logic tk, input logic mp);
    logic nrdy [NUM_PREG];
    logic nsnap [NUM_PREG];
    logic wr, al;
    @(negedge clk);
    nr_valid = nv; nr_reg = nr; wb_valid = wv;
    wb_preg[0] = w0; wb_preg[1] = w1; wb_preg[2] = w2;
    q_preg[0] = q0; q_preg[1] = q1; ckpt_take = tk; mispredict = mp;
    #1;
    s_q = q_ready;
    check("q_ready0", q_ready[0], q_exp(q0, wv, w0, w1, w2));
    check("q_ready1", q_ready[1], q_exp(q1, wv, w0, w1, w2));
    @(posedge clk);
    for (int t = 0; t < NUM_PREG; t++) begin
      wr = (t != 0) && ((wv[0] && w0 == t) || (wv[1] && w1 == t) || (wv[2] && w2 == t));
      al = (t != 0) && nv && (nr == t);
      nsnap[t] = snap_m[t];
      if (mp) begin
        nrdy[t] = (snapv_m ? snap_m[t] : ready_m[t]) | wr;
      end else begin
        nrdy[t] = (ready_m[t] | wr) & ~al;
        if (tk) nsnap[t] = nrdy[t];
        else if (snapv_m) nsnap[t] = snap_m[t] | wr;
      end
    end
    ready_m = nrdy;
    snap_m  = nsnap;
    snapv_m = mp ? 1'b0 : (tk ? 1'b1 : snapv_m);
    #1;
    s_bv = {preg3_valid, preg2_valid, preg1_valid};
    s_b1 = preg1_rdy; s_b2 = preg2_rdy; s_b3 = preg3_rdy; s_ck = ckpt_valid;
    check("b1_valid", preg1_valid, wv[0]);
    check("b2_valid", preg2_valid, wv[1]);
    check("b3_valid", preg3_valid, wv[2]);
    check("b1_tag", preg1_rdy, w0);
    check("b2_tag", preg2_rdy, w1);
    check("b3_tag", preg3_rdy, w2);
    check("ckpt_valid", ckpt_valid, snapv_m);
  endtask

  task automatic rand_cyc();
    int busy[$];
    logic [2:0] wv;
    preg_t w [3];
    preg_t q [2];
    busy = {};
    for (int t = 1; t < NUM_PREG; t++) if (!ready_m[t]) busy.push_back(t);
    for (int p = 0; p < 3; p++) begin
      wv[p] = 1'b0;
      w[p]  = preg_t'($urandom_range(0, NUM_PREG - 1));
      if ($urandom_range(0, 9) < 4 && busy.size() > 0) begin
        wv[p] = 1'b1;
        w[p]  = preg_t'(busy[$urandom_range(0, busy.size() - 1)]);
      end else if ($urandom_range(0, 19) == 0) begin
        wv[p] = 1'b1;
        w[p]  = '0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if ($urandom_range(0, 1) == 1 && busy.size() > 0)
        q[i] = preg_t'(busy[$urandom_range(0, busy.size() - 1)]);
      else
        q[i] = preg_t'($urandom_range(0, NUM_PREG - 1));
    end
    cyc(1'($urandom_range(0, 1)), preg_t'($urandom_range(0, NUM_PREG - 1)), wv, w[0], w[1], w[2],
        q[0], q[1], $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
  endtask

  initial begin
    model_reset();
    do_reset();
    cyc(0, 0, 3'b000, 0, 0, 0, 0, 127, 0, 0);
    check("rst_q0", s_q[0], 1'b1);
    check("rst_q127", s_q[1], 1'b1);

    cyc(1, 40, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 3'b000, 0, 0, 0, 40, 5, 0, 0);
    check("t1_q40_busy", s_q[0], 1'b0);
    check("t1_q5_ready", s_q[1], 1'b1);

    cyc(0, 0, 3'b010, 0, 40, 0, 40, 0, 0, 0);
    check("t2_bypass", s_q[0], 1'b1);
    check("t2_b2_tag", s_b2, 7'd40);
    check("t2_bvalid", s_bv, 3'b010);

    cyc(1, 55, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 55, 3'b001, 55, 0, 0, 0, 0, 0, 0);
    check("t3_b1_tag", s_b1, 7'd55);
    cyc(0, 0, 3'b000, 0, 0, 0, 55, 0, 0, 0);
    check("t3_q55_busy", s_q[0], 1'b0);

    cyc(1, 60, 3'b000, 0, 0, 0, 0, 0, 1, 0);
    check("t4_ckpt_set", s_ck, 1'b1);
    cyc(1, 61, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 62, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 3'b001, 60, 0, 0, 61, 62, 0, 0);
    check("t4_q61_busy", s_q[0], 1'b0);
    cyc(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1);
    check("t4_ckpt_clr", s_ck, 1'b0);
    cyc(0, 0, 3'b000, 0, 0, 0, 60, 61, 0, 0);
    check("t4_q60", s_q[0], 1'b1);
    check("t4_q61", s_q[1], 1'b1);
    cyc(0, 0, 3'b000, 0, 0, 0, 62, 55, 0, 0);
    check("t4_q62", s_q[0], 1'b1);
    check("t4_q55_busy", s_q[1], 1'b0);

    cyc(1, 70, 3'b000, 0, 0, 0, 0, 0, 1, 1);
    check("t5_no_ckpt", s_ck, 1'b0);
    cyc(0, 0, 3'b000, 0, 0, 0, 70, 0, 0, 0);
    check("t5_q70", s_q[0], 1'b1);

    cyc(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    check("t6_q0_a", s_q[0], 1'b1);
    cyc(0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0);
    check("t6_q0_b", s_q[0], 1'b1);
    cyc(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    check("t6_q0_c", s_q[0], 1'b1);

    for (int i = 0; i < 300; i++) rand_cyc();
    cyc(1, 90, 3'b000, 0, 0, 0, 0, 0, 1, 0);
    do_reset();
    cyc(0, 0, 3'b000, 0, 0, 0, 90, 55, 0, 0);
    check("mid_rst_q90", s_q[0], 1'b1);
    check("mid_rst_ckpt", s_ck, 1'b0);
    for (int i = 0; i < 300; i++) rand_cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/preg_ready_table.md
Name: preg_ready_table

Overview:
- Physical-register ready scoreboard on the far side of dispatch's PRF interface.
- Consumes allocation notices (dispatch_nr_reg/valid) and clears the ready bit of each newly allocated destination.
- Sets ready bits on FU writeback and re-broadcasts those writebacks one cycle later on the preg1/2/3 ready ports read by all reservation stations.
- Answers rename-time readiness queries, and holds one branch checkpoint for mispredict recovery.

Parameters:
- NUM_PREG, 128, number of physical registers; tag width is $clog2(NUM_PREG) = 7.
- NUM_WB, 3, writeback ports; fixed at 3 to match preg1..preg3.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- nr_valid  in  1  allocate strobe from dispatch_nr_valid
- nr_reg  in  7  preg being allocated; its ready bit is cleared
- wb_valid  in  3  per-port FU writeback strobe
- wb_preg  in  3x7  per-port written preg
- q_preg  in  2x7  rename-time lookup tags (ps1, ps2)
- q_ready  out  2  lookup results, combinational
- preg1_rdy, preg2_rdy, preg3_rdy  out  7 each  registered writeback broadcast tags
- preg1_valid, preg2_valid, preg3_valid  out  1 each  broadcast qualifiers
- ckpt_take  in  1  snapshot request (branch dispatch)
- mispredict  in  1  restore request
- ckpt_valid  out  1  a snapshot is held

Behaviour:
- State:
  - ready[NUM_PREG-1:0]
  - snap[NUM_PREG-1:0] and snap_v
  - three broadcast registers, each a tag plus a valid bit
- Reset (reset==0 at posedge):
  - ready <= all 1s; snap <= all 1s; snap_v <= 0.
  - All pregN_valid <= 0 and pregN_rdy <= 0; ckpt_valid = 0.
- Preg 0 is hardwired ready:
  - nr and wb accesses to tag 0 are ignored.
  - A q_ready lookup of tag 0 always returns 1.
- Per-cycle next-state of ready, with both steps applied in the same cycle:
  1. set = OR of decoded wb ports; clr = decoded nr.
  2. ready_next = (ready | set) & ~clr. Clear wins when the same tag is written back and allocated in one cycle; a wb to a just-allocated tag is stale.
- Broadcast: pregN_rdy/valid <= wb_preg[N-1]/wb_valid[N-1], giving exactly 1-cycle latency. This is unaffected by mispredict, because older instructions still complete.
- Query, combinational:
  - q_ready[i] = ready[q_preg[i]] | (a same-cycle wb matches q_preg[i]).
  - Allocation in the same cycle is NOT bypassed.
- Checkpoint:
  - ckpt_take with no mispredict: snap <= ready_next and snap_v <= 1. A take while snap_v==1 overwrites the snapshot (single level).
  - While snap_v==1 and no take: snap <= snap | set, so writebacks that happen after the snapshot are accumulated.
- Mispredict:
  - If snap_v: ready <= snap | set, then snap_v <= 0.
  - If !snap_v: ready <= ready | set, i.e. only the nr clear is suppressed.
  - The nr of that cycle is dropped.
  - Mispredict outranks ckpt_take in the same cycle; no snapshot is taken.
- Duplicate tags across wb ports are legal; the set is idempotent.
- Reset mid-operation discards the snapshot and any in-flight broadcasts.
- Verification assertion (sim only): no wb to a preg whose ready bit is already 1, except tag 0.

Decomposition:
- types_pkg additions:
  - PREG_W = 7 and NUM_PREG = 128 constants.
  - typedef preg_t (logic [6:0]).
  - typedef wb_bcast_t struct {preg_t tag; logic valid}.
- One natural sub-module: preg_onehot_dec, a 7-to-128 decoder with enable. It is instantiated 4 times: 3 wb ports and 1 nr port.

Test Plan:
1. Reset then nr_valid=1, nr_reg=7'd40 -> the next cycle q_preg[0]=40 gives q_ready[0]=0, and tag 5 still reads 1.
2. With preg 40 busy, wb_valid=3'b010, wb_preg[1]=40 -> in the same cycle q_ready=1 (bypass); the next cycle preg2_rdy=40 and preg2_valid=1, with preg1/3_valid=0.
3. In one cycle, nr_reg=55 and wb port0=55 -> ready[55]=0 afterwards, and preg1_rdy=55 is broadcast.
4. Sequence:
   - Allocate 60 and take a checkpoint.
   - Next cycle, allocate 61 and 62.
   - Then wb 60.
   - Then mispredict.
   - Required: 60 reads ready, 61 and 62 read ready (restored), and ckpt_valid=0.
5. Mispredict and ckpt_take in the same cycle with nr_reg=70 -> no snapshot (ckpt_valid=0) and ready[70] stays 1.
6. nr_reg=0, then wb to 0 and q_preg=0 -> q_ready=1 throughout, and the assertion does not fire.
